// File: rtl/serial_eq_checker_pkg.sv
// Shared definitions for the serial word-equality checker.
// Holds the FSM state encoding used by the top level.
package serial_eq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_eq_checker_bit_eq.sv
// One-bit equality cell: s is high when a and b carry the same value.
// Purely combinational; the word-level reduction lives in the top level.
module bit_eq (
    input  logic a,
    input  logic b,
    output logic s
);

    assign s = ~(a ^ b);

endmodule

// File: rtl/serial_eq_checker.sv
// Serial word-equality checker: compares two LSB-first operands one bit pair per
// valid cycle and reports word equality plus the index of the first differing bit.
module serial_eq_checker
    import serial_eq_checker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [IDX_W-1:0] mismatch_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             acc;
    logic             eqb;

    bit_eq u_bit_eq (
        .a (a_bit),
        .b (b_bit),
        .s (eqb)
    );

    // NOTE: every register here updates with <= so all of them see the
    // pre-edge values of acc/cnt; blocking writes would leak new values forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
            cnt          <= '0;
            acc          <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_COMPARE;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        acc          <= 1'b1;
                        equal        <= 1'b0;
                        mismatch_idx <= '0;
                    end
                end

                ST_COMPARE: begin
                    if (valid) begin
                        // acc is still 1 only until the first mismatch, so later
                        // mismatches never overwrite the captured index.
                        if (acc && !eqb) begin
                            mismatch_idx <= cnt;
                        end
                        acc <= acc & eqb;
                        if (cnt == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            equal <= acc & eqb;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_eq_checker.sv
// Directed bench for serial_eq_checker: a driver queues expected results and a
// monitor pops and compares them whenever done pulses.
module tb_serial_eq_checker;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef struct {
        logic             eq;
        logic [IDX_W-1:0] idx;
        int               done_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDX_W-1:0] mismatch_idx;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_eq_checker #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .valid        (valid),
        .a_bit        (a_bit),
        .b_bit        (b_bit),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatch_idx)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_done: done pulsed with no comparison pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_equal", int'(equal), int'(e.eq));
                check("done_mismatch_idx", int'(mismatch_idx), int'(e.idx));
                check("done_latency_cycle", cyc, e.done_cyc);
                check("busy_in_done", int'(busy), 1);
            end
        end
    end

    // stalls: nibble i holds the number of valid=0 cycles inserted after bit i.
    task automatic do_cmp(input logic [7:0] a, input logic [7:0] b,
                          input logic exp_eq, input logic [IDX_W-1:0] exp_idx,
                          input logic [31:0] stalls, input logic hold_start,
                          input logic pulse_in_stall);
        int   total;
        logic pulsed;
        exp_t e;
        total  = 0;
        pulsed = 1'b0;
        for (int i = 0; i < WIDTH; i++) total += int'(stalls[4*i +: 4]);
        @(posedge clk); #1;
        start      = 1'b1;
        valid      = 1'b0;
        e.eq       = exp_eq;
        e.idx      = exp_idx;
        e.done_cyc = cyc + WIDTH + 1 + total;
        sb.push_back(e);
        for (int i = 0; i < WIDTH; i++) begin
            @(posedge clk); #1;
            start = hold_start;
            valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            if (i == 0) check("busy_in_compare", int'(busy), 1);
            for (int j = 0; j < int'(stalls[4*i +: 4]); j++) begin
                @(posedge clk); #1;
                valid = 1'b0;
                a_bit = ~a[i];
                b_bit = a[i];
                start = hold_start | (pulse_in_stall & ~pulsed);
                pulsed = 1'b1;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        start = hold_start;
    endtask

    task automatic check_hold(input string tag, input logic exp_eq, input logic [IDX_W-1:0] exp_idx);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_equal"}, int'(equal), int'(exp_eq));
        check({tag, "_hold_idx"}, int'(mismatch_idx), int'(exp_idx));
        check({tag, "_hold_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        a_bit = 1'b0;
        b_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_equal", int'(equal), 0);
        check("reset_idx", int'(mismatch_idx), 0);

        // Equal words, no stalls.
        do_cmp(8'hA5, 8'hA5, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        check_hold("eq_a5", 1'b1, 3'd0);

        // First-mismatch index cases.
        do_cmp(8'hA5, 8'hA4, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        check_hold("mm_bit0", 1'b0, 3'd0);
        do_cmp(8'h80, 8'h00, 1'b0, 3'd7, 32'h0, 1'b0, 1'b0);
        check_hold("mm_bit7", 1'b0, 3'd7);
        do_cmp(8'hFF, 8'h0F, 1'b0, 3'd4, 32'h0, 1'b0, 1'b0);
        check_hold("mm_bit4", 1'b0, 3'd4);

        // Stalls of 3 cycles after bit 2 and 1 after bit 5, start pulsed mid-stall.
        do_cmp(8'h3C, 8'h3C, 1'b1, 3'd0, 32'h0010_0300, 1'b0, 1'b1);
        check_hold("stall", 1'b1, 3'd0);

        // Abort after 4 valid bits: no done pulse, outputs cleared.
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            valid = 1'b1;
            a_bit = 1'b1;
            b_bit = 1'b0;
        end
        @(posedge clk); #1;
        valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_equal", int'(equal), 0);
        check("abort_idx", int'(mismatch_idx), 0);
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("abort_busy_later", int'(busy), 0);
        do_cmp(8'h11, 8'h11, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);

        // start held high across two back-to-back comparisons.
        do_cmp(8'h5A, 8'h5A, 1'b1, 3'd0, 32'h0, 1'b1, 1'b0);
        do_cmp(8'hC3, 8'hC1, 1'b0, 3'd1, 32'h0, 1'b1, 1'b0);
        start = 1'b0;
        check_hold("b2b", 1'b0, 3'd1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
